// File: rtl/mcu_pipe_pkg.sv
// Shared pipeline definitions for the MCU hazard logic: default register
// address width, scoreboard depth, the hardwired-zero register address and
// the scoreboard entry layout.
package mcu_pipe_pkg;

  localparam int AW_DEF    = 3;
  localparam int DEPTH_DEF = 2;

  localparam logic [AW_DEF-1:0] R0 = '0;

  // One in-flight instruction ahead of decode: valid flag and destination.
  typedef struct packed {
    logic              v;
    logic [AW_DEF-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/hazard_cmp.sv
// Per-stage comparator: flags whether the decode operands read the register
// that this scoreboard entry is going to write.
module hazard_cmp
  import mcu_pipe_pkg::*;
(
  input  sb_entry_t         entry,
  input  logic [AW_DEF-1:0] AA,
  input  logic [AW_DEF-1:0] BA,
  input  logic              MA,
  input  logic              MB,
  input  logic              valid_in,
  output logic              match_a,
  output logic              match_b
);

  // R0 is never tracked, so a valid entry always holds a real register.
  assign match_a = valid_in & ~MA & entry.v & (entry.dst == AA);
  assign match_b = valid_in & ~MB & entry.v & (entry.dst == BA);

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for the MCU pipeline. Shifts the destinations of up
// to DEPTH in-flight instructions, raises the active-low stall DHS while a
// decode operand depends on one of them, and clears everything on flush.
// Optional macro HAZARD_FWD_EN: the oldest stage (DEPTH) is bypassed instead
// of stalled, reported on fwd_a/fwd_b.
// AW must equal the package width AW_DEF (the entry type is sized by it).
module hazard_scoreboard
  import mcu_pipe_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [AW-1:0]    AA,
  input  logic [AW-1:0]    BA,
  input  logic             MA,
  input  logic             MB,
  input  logic [AW-1:0]    DA,
  input  logic             RW,
  input  logic             flush,
  output logic             DHS,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH:1] sb_v;
  logic [AW-1:0]  sb_dst [1:DEPTH];
  sb_entry_t      sb_e   [1:DEPTH];
  logic [DEPTH:1] m_a;
  logic [DEPTH:1] m_b;
  logic           hz_a;
  logic           hz_b;
  logic           fa;
  logic           fb;

  genvar g;
  generate
    for (g = 1; g <= DEPTH; g++) begin : g_cmp
      assign sb_e[g].v   = sb_v[g];
      assign sb_e[g].dst = sb_dst[g];
      hazard_cmp u_cmp (
        .entry    (sb_e[g]),
        .AA       (AA),
        .BA       (BA),
        .MA       (MA),
        .MB       (MB),
        .valid_in (valid_in),
        .match_a  (m_a[g]),
        .match_b  (m_b[g])
      );
    end
  endgenerate

  // Combine stage matches into stall flags; the oldest stage either stalls or forwards.
  always_comb begin
    hz_a = 1'b0;
    hz_b = 1'b0;
    fa   = 1'b0;
    fb   = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      hz_a = hz_a | m_a[k];
      hz_b = hz_b | m_b[k];
    end
`ifdef HAZARD_FWD_EN
    fa = m_a[DEPTH] & ~hz_a;
    fb = m_b[DEPTH] & ~hz_b;
`else
    hz_a = hz_a | m_a[DEPTH];
    hz_b = hz_b | m_b[DEPTH];
`endif
  end

  assign hazard_a = hz_a;
  assign hazard_b = hz_b;
  assign fwd_a    = fa;
  assign fwd_b    = fb;
  assign DHS      = flush | ~(hz_a | hz_b);

  // Valid bits: shift each cycle, bubble into stage 1 on stall, clear on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_v <= '0;
    end else if (flush) begin
      sb_v <= '0;
    end else begin
      sb_v[1] <= DHS & valid_in & RW & (DA != R0);
      for (int k = 2; k <= DEPTH; k++) begin
        sb_v[k] <= sb_v[k-1];
      end
    end
  end

  // Destination addresses shift unconditionally; they are qualified by sb_v.
  always_ff @(posedge clk) begin
    sb_dst[1] <= DA;
    for (int k = 2; k <= DEPTH; k++) begin
      sb_dst[k] <= sb_dst[k-1];
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!DHS && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic, all checked against a model that tracks, per register, the cycle
// at which its most recent in-flight write entered the pipeline.
module tb_hazard_scoreboard;

  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int SLIM = FWD ? DEPTH - 1 : DEPTH;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             valid_in = 1'b0;
  logic [AW-1:0]    AA = '0;
  logic [AW-1:0]    BA = '0;
  logic             MA = 1'b0;
  logic             MB = 1'b0;
  logic [AW-1:0]    DA = '0;
  logic             RW = 1'b0;
  logic             flush = 1'b0;
  logic             DHS;
  logic             hazard_a;
  logic             hazard_b;
  logic             fwd_a;
  logic             fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .AA        (AA),
    .BA        (BA),
    .MA        (MA),
    .MB        (MB),
    .DA        (DA),
    .RW        (RW),
    .flush     (flush),
    .DHS       (DHS),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edge count since reset, entry edge of the latest write per register.
  int cyc;
  int last_wr [8];
  int m_cnt;
  bit last_dhs;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 8; r++) last_wr[r] = -1000;
  endfunction

  // A write that entered at edge E sits in stage cyc-E+1.
  function automatic bit m_hz(input logic [AW-1:0] a, input logic m);
    int age;
    age = cyc - last_wr[a];
    return valid_in && !m && (a != 0) && (age >= 0) && (age < SLIM);
  endfunction

  function automatic bit m_fwd(input logic [AW-1:0] a, input logic m);
    return FWD && valid_in && !m && (a != 0) && ((cyc - last_wr[a]) == DEPTH - 1);
  endfunction

  task automatic set_in(input bit v, input int aa, input int ba, input bit ma,
                        input bit mb, input int da, input bit rw, input bit fl);
    valid_in = v; AA = aa[AW-1:0]; BA = ba[AW-1:0]; MA = ma; MB = mb;
    DA = da[AW-1:0]; RW = rw; flush = fl;
  endtask

  // Called just after a falling edge with inputs applied: check, then take one rising edge.
  task automatic step();
    bit ha, hb, dh;
    #1;
    ha = m_hz(AA, MA);
    hb = m_hz(BA, MB);
    dh = flush || !(ha || hb);
    check("dhs", DHS, dh);
    check("hazard_a", hazard_a, ha);
    check("hazard_b", hazard_b, hb);
    check("fwd_a", fwd_a, m_fwd(AA, MA));
    check("fwd_b", fwd_b, m_fwd(BA, MB));
    check("stall_cnt", stall_cnt, m_cnt);
    last_dhs = DHS;
    @(posedge clk);
    cyc++;
    if (!dh && m_cnt != 15) m_cnt++;
    if (flush) model_clear();
    else if (dh && valid_in && RW && DA != 0) last_wr[DA] = cyc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_dhs", DHS, 1);
    check("rst_cnt", stall_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_hz", hazard_a | hazard_b | fwd_a | fwd_b, 0);
    rst = 1'b0;
    cyc = 0; m_cnt = 0; model_clear();
  endtask

  // Keep decode held until it proceeds; returns the number of stalled cycles.
  task automatic hold_until_go(output int stalls);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_dhs) return;
      stalls++;
    end
    check("stall_bound", stalls, -1);
  endtask

  int st;

  initial begin
    @(negedge clk);
    do_reset();

    // Back-to-back dependence on R3.
    set_in(1, 0, 0, 0, 1, 3, 1, 0); step();
    set_in(1, 3, 0, 0, 1, 0, 0, 0);
    hold_until_go(st);
    check("t1_stalls", st, FWD ? 1 : 2);
    check("t1_cnt", stall_cnt, FWD ? 1 : 2);

    // R0 writes and non-register operands never hazard.
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 1, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0); #1; check("t2_r0", DHS, 1); step();
    set_in(1, 0, 0, 1, 0, 3, 1, 0); step();
    set_in(1, 0, 3, 1, 1, 0, 0, 0); #1; check("t2_mb", DHS, 1); step();

    // Dependence two instructions back (stage DEPTH).
    do_reset();
    set_in(1, 0, 0, 1, 1, 3, 1, 0); step();
    set_in(1, 1, 2, 0, 0, 4, 0, 0); step();
    set_in(1, 0, 3, 1, 0, 0, 0, 0);
    #1; check("t3_fwd_b", fwd_b, FWD ? 1 : 0);
    hold_until_go(st);
    check("t3_stalls", st, FWD ? 0 : 1);

    // Flush during a stall.
    do_reset();
    set_in(1, 0, 0, 1, 1, 3, 1, 0); step();
    set_in(1, 3, 0, 0, 1, 0, 0, 0); #1; check("t4_stall", DHS, 0);
    flush = 1'b1; #1; check("t4_flush_dhs", DHS, 1); step();
    flush = 1'b0; #1; check("t4_after", DHS, 1); step();

    // Two writes to R5, then a read: youngest match decides.
    do_reset();
    set_in(1, 0, 0, 1, 1, 5, 1, 0); step();
    set_in(1, 0, 0, 1, 1, 5, 1, 0); step();
    set_in(1, 5, 0, 0, 1, 0, 0, 0);
    #1; check("t5_fwd_stall", fwd_a, 0);
    hold_until_go(st);
    check("t5_stalls", st, FWD ? 1 : 2);

    // Saturation of the stall counter, then asynchronous reset mid-stall.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_in(1, 0, 0, 1, 1, 3, 1, 0); step();
      set_in(1, 3, 0, 0, 1, 0, 0, 0); hold_until_go(st);
    end
    check("t6_sat", stall_cnt, 15);
    set_in(1, 0, 0, 1, 1, 3, 1, 0); step();
    set_in(1, 3, 0, 0, 1, 0, 0, 0);
    #1; check("t6_in_stall", DHS, 0);
    #1; rst = 1'b1;
    #1; check("t6_async_dhs", DHS, 1);
    check("t6_async_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; m_cnt = 0; model_clear();

    // Random traffic; a stalled decode holds its instruction.
    for (int i = 0; i < 500; i++) begin
      if (last_dhs || flush) begin
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 7), $urandom_range(0, 2) != 0, 0);
      end
      flush = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
